// File: rtl/seg_scan_driver.sv
// seg_scan_driver: self-timed scan multiplexer for common-anode 7-segment /
// LED-group displays. An internal prescaler walks the digit index; the
// active digit's nibble, point and LE bits are routed out with dead time,
// per-digit blink and leading-zero blanking applied to the anode enables.
// All outputs are registered, one cycle behind the internal scan state.
module seg_scan_driver #(
  parameter int DIGITS       = 8,
  parameter int SCAN_DIV     = 100000,
  parameter int DEAD         = 2,
  parameter int BLINK_FRAMES = 64,
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   hexs,
  input  logic [DIGITS-1:0]     points,
  input  logic [DIGITS-1:0]     les,
  input  logic [DIGITS-1:0]     blink,
  input  logic                  lz_blank,
  output logic [3:0]            hex,
  output logic                  p,
  output logic                  le,
  output logic [DIGITS-1:0]     an,
  output logic [IW-1:0]         scan
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEAD_C     = CW'(DEAD);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [DIGITS-1:0] ONE_HOT0 = {{(DIGITS-1){1'b0}}, 1'b1};

  // scan state: prescaler count, digit index, frame count, blink phase
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [FW-1:0] frame;
  logic          phase;

  logic slot_end;
  logic frame_end;

  assign slot_end  = en && (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);

  // Prescaler, digit index and blink framing; everything freezes while en=0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      idx   <= '0;
      frame <= '0;
      phase <= 1'b0;
    end else if (en) begin
      if (slot_end) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end else begin
        cnt <= cnt + CW'(1);
      end
      if (frame_end) begin
        if (frame == FRAME_LAST) begin
          frame <= '0;
          phase <= ~phase;
        end else begin
          frame <= frame + FW'(1);
        end
      end
    end
  end

  // zero_from_p0[i] is set when nibbles i..DIGITS-1 are all zero, i.e.
  // digit i lies inside the leading-zero run
  logic [DIGITS-1:0] zero_from_p0;

  // Leading-zero run detection, scanning down from the most significant digit
  always_comb begin
    zero_from_p0 = '0;
    zero_from_p0[DIGITS-1] = (hexs[4*(DIGITS-1) +: 4] == 4'h0);
    for (int i = DIGITS - 2; i >= 0; i--) begin
      zero_from_p0[i] = zero_from_p0[i+1] && (hexs[4*i +: 4] == 4'h0);
    end
  end

  logic blank_p0;

  // Anode blanking decision for the current slot; digit 0 never counts as a
  // leading zero so a value of zero still shows a single "0"
  always_comb begin
    blank_p0 = 1'b0;
    if (!en)                                      blank_p0 = 1'b1;
    if (cnt < DEAD_C)                             blank_p0 = 1'b1;
    if (blink[idx] && phase)                      blank_p0 = 1'b1;
    if (lz_blank && (idx != '0) && zero_from_p0[idx]) blank_p0 = 1'b1;
  end

  // Output register: data follows idx unconditionally, only anodes are blanked
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex  <= 4'h0;
      p    <= 1'b0;
      le   <= 1'b0;
      an   <= '1;
      scan <= '0;
    end else begin
      hex  <= hexs[{idx, 2'b00} +: 4];
      p    <= points[idx];
      le   <= les[idx];
      scan <= idx;
      an   <= blank_p0 ? '1 : ~(ONE_HOT0 << idx);
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Testbench for seg_scan_driver (DIGITS=4, SCAN_DIV=4, DEAD=1, BLINK_FRAMES=2).
// A reference model derives the expected outputs from a count of enabled
// clock cycles since reset; expectations are queued at drive time and
// popped when the DUT output is sampled one cycle later.
module tb_seg_scan_driver;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;
  localparam int DEAD     = 1;
  localparam int BF       = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] hexs = 16'h0;
  logic [3:0]  points = 4'h0;
  logic [3:0]  les = 4'h0;
  logic [3:0]  blink = 4'h0;
  logic        lz_blank = 1'b0;

  logic [3:0]  hex;
  logic        p;
  logic        le;
  logic [3:0]  an;
  logic [1:0]  scan;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [3:0] hex;
    logic       p;
    logic       le;
    logic [3:0] an;
    logic [1:0] scan;
  } exp_t;

  exp_t sb[$];
  int   m_t = 0;     // enabled cycles since reset
  int   lit[4];

  logic [3:0] an_tbl [16] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
                              4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7};

  seg_scan_driver #(
    .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .DEAD(DEAD), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .hexs(hexs), .points(points),
    .les(les), .blink(blink), .lz_blank(lz_blank),
    .hex(hex), .p(p), .le(le), .an(an), .scan(scan)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    int   c;
    int   d;
    bit   ph;
    bit   blk;
    logic [15:0] upper;
    c = m_t % SCAN_DIV;
    d = (m_t / SCAN_DIV) % DIGITS;
    ph = ((m_t / (SCAN_DIV * DIGITS * BF)) % 2) == 1;
    upper = hexs >> (4 * d);
    e.hex  = upper[3:0];
    e.p    = points[d];
    e.le   = les[d];
    e.scan = 2'(d);
    blk = !en || (c < DEAD) || (blink[d] && ph) ||
          (lz_blank && d != 0 && upper == 16'h0);
    e.an = blk ? 4'hF : ~(4'b0001 << d);
    return e;
  endfunction

  task automatic step();
    exp_t e;
    sb.push_back(model_out());
    if (en) m_t++;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk("an",   32'(an),   32'(e.an));
      chk("hex",  32'(hex),  32'(e.hex));
      chk("p",    32'(p),    32'(e.p));
      chk("le",   32'(le),   32'(e.le));
      chk("scan", 32'(scan), 32'(e.scan));
    end
  endtask

  task automatic count_lit(input int n);
    for (int d = 0; d < 4; d++) lit[d] = 0;
    for (int i = 0; i < n; i++) begin
      step();
      for (int d = 0; d < 4; d++)
        if (an == ~(4'b0001 << d)) lit[d]++;
    end
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_an",   32'(an),   32'hF);
    chk("rst_hex",  32'(hex),  32'h0);
    chk("rst_p",    32'(p),    32'h0);
    chk("rst_le",   32'(le),   32'h0);
    chk("rst_scan", 32'(scan), 32'h0);

    // dead time and scan order
    en = 1'b1;
    hexs = 16'h4321;
    @(negedge clk);
    rst_n = 1'b1;
    m_t = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("an_seq",  32'(an),  32'(an_tbl[i % 16]));
      chk("hex_seq", 32'(hex), 32'((i / 4) % 4 + 1));
    end

    // point / LE routing
    points = 4'b0101;
    les    = 4'b1000;
    for (int i = 0; i < 16; i++) step();

    // leading-zero blanking
    lz_blank = 1'b1;
    hexs = 16'h0070;
    count_lit(16);
    chk("lz_d0", 32'(lit[0]), 32'd3);
    chk("lz_d1", 32'(lit[1]), 32'd3);
    chk("lz_d2", 32'(lit[2]), 32'd0);
    chk("lz_d3", 32'(lit[3]), 32'd0);
    hexs = 16'h0000;
    count_lit(16);
    chk("lz0_d0", 32'(lit[0]), 32'd3);
    chk("lz0_d1", 32'(lit[1] + lit[2] + lit[3]), 32'd0);
    lz_blank = 1'b0;
    hexs = 16'h4321;

    // blink: digit 1 lit half the frames, others always
    blink = 4'b0010;
    count_lit(128);
    chk("blink_d1", 32'(lit[1]), 32'd12);
    chk("blink_d0", 32'(lit[0]), 32'd24);
    chk("blink_d2", 32'(lit[2]), 32'd24);

    // en gap with register cnt=3 in slot 1
    blink = 4'b0000;
    for (int i = 0; i < 16 && (m_t % 16) != 7; i++) step();
    chk("en_align", 32'(m_t % 16), 32'd7);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("gap_an",   32'(an),   32'hF);
      chk("gap_scan", 32'(scan), 32'd1);
    end
    en = 1'b1;
    step();
    chk("resume_an", 32'(an), 32'hD);
    step();
    chk("resume_dead", 32'(an), 32'hF);
    chk("resume_scan", 32'(scan), 32'd2);
    for (int i = 0; i < 8; i++) step();

    // asynchronous reset mid-slot 2
    for (int i = 0; i < 16 && (m_t % 16) != 10; i++) step();
    chk("rst_align", 32'(scan), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_an",   32'(an),   32'hF);
    chk("arst_hex",  32'(hex),  32'h0);
    chk("arst_scan", 32'(scan), 32'h0);
    sb.delete();
    m_t = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rel_dead", 32'(an), 32'hF);
    step();
    chk("rel_first", 32'(an), 32'hE);
    chk("rel_hex",   32'(hex), 32'h1);
    for (int i = 0; i < 16; i++) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
